// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit frame builder.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DROP,
    CSUM,
    HDR,
    PAY
  } state_t;

  localparam int ETH_HDR   = 14;
  localparam int IP_HDR    = 20;
  localparam int UDP_HDR   = 8;
  localparam int TOTAL_HDR = ETH_HDR + IP_HDR + UDP_HDR;

  // Payload length width; 1472 bytes fits in 11 bits.
  localparam int LEN_W = 11;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  // One's-complement fold of a 32-bit sum down to 16 bits with end-around carry.
  // Two passes suffice: after the first the carry is at most one bit.
  function automatic logic [15:0] csum_fold(input logic [31:0] acc);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    s = {1'b0, s[15:0]} + {16'h0000, s[16]};
    return s[15:0];
  endfunction

endpackage

// File: rtl/udp_payload_ram.sv
// Payload buffer: one write port, one read port, registered read data.
module udp_payload_ram #(
  parameter int DEPTH = 1472,
  parameter int AW    = 11
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [0:DEPTH-1];

  // Store incoming payload bytes
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Synchronous read, one cycle of latency
  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_builder.sv
// Buffers one payload frame, computes IPv4/UDP checksums, then emits the
// Ethernet/IPv4/UDP header followed by the payload into the output FIFO.
module udp_builder
  import udp_pkg::*;
#(
  parameter int          MAX_PAYLOAD = 1472,
  parameter logic [47:0] SRC_MAC     = 48'h0,
  parameter logic [47:0] DST_MAC     = 48'h0,
  parameter logic [31:0] SRC_IP      = 32'h0,
  parameter logic [31:0] DST_IP      = 32'h0,
  parameter logic [15:0] SRC_PORT    = 16'h0,
  parameter logic [15:0] DST_PORT    = 16'h0,
  parameter logic [7:0]  TTL         = 8'd64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       in_empty,
  output logic       in_rd_en,
  output logic [7:0] dout,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_wr_en,
  input  logic       out_full
);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);
  localparam logic [5:0]       HDR_LAST = 6'(TOTAL_HDR - 1);

  state_t             state;
  logic               csum_phase;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   pay_idx;
  logic [5:0]         hcnt;
  logic [5:0]         hrev;
  logic [31:0]        udp_acc;
  logic [31:0]        ip_acc;
  logic [15:0]        ident;
  logic [15:0]        udp_csum;
  logic [15:0]        ip_csum;
  logic [15:0]        total_len;
  logic [15:0]        udp_len;
  logic               last_pay;
  logic [TOTAL_HDR*8-1:0] hdr_vec;

  logic               ram_we;
  logic [LEN_W-1:0]   ram_waddr;
  logic [LEN_W-1:0]   ram_raddr;
  logic [7:0]         rd_data;

  assign total_len = {5'd0, len} + 16'(IP_HDR + UDP_HDR);
  assign udp_len   = {5'd0, len} + 16'(UDP_HDR);
  assign last_pay  = (pay_idx == len - 11'd1);

  // Header image, first transmitted byte in the most significant position.
  assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, total_len, ident, 16'h4000, TTL, IP_PROTO_UDP, ip_csum,
                    SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len, udp_csum};

  // FIFO handshakes and output byte selection; everything forced low in reset
  always_comb begin
    hrev      = HDR_LAST - hcnt;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    dout      = 8'h00;
    if (reset) begin
      in_rd_en  = !in_empty && (state == IDLE || state == LOAD || state == DROP);
      out_wr_en = !out_full && (state == HDR || state == PAY);
      if (state == HDR) begin
        dout    = hdr_vec[{hrev, 3'b000} +: 8];
        out_sof = (hcnt == 6'd0);
      end else if (state == PAY) begin
        dout    = rd_data;
        out_eof = last_pay;
      end
    end
  end

  // Buffer write on accepted bytes; read address only advances on a written payload byte
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = len;
    if (in_rd_en) begin
      if (in_sof && (state == IDLE || state == LOAD)) begin
        ram_we    = 1'b1;
        ram_waddr = '0;
      end else if (state == LOAD && len != MAX_LEN) begin
        ram_we = 1'b1;
      end
    end
    ram_raddr = (state == PAY && out_wr_en && !last_pay) ? pay_idx + 11'd1 : pay_idx;
  end

  udp_payload_ram #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (LEN_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (din),
    .rd_addr (ram_raddr),
    .rd_data (rd_data)
  );

  // Frame sequencing: load, checksum, header, payload
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      csum_phase <= 1'b0;
      len        <= '0;
      pay_idx    <= '0;
      hcnt       <= '0;
      udp_acc    <= '0;
      ip_acc     <= '0;
      ident      <= '0;
      udp_csum   <= '0;
      ip_csum    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_rd_en && in_sof) begin
            len     <= 11'd1;
            udp_acc <= {16'h0000, din, 8'h00};
            state   <= in_eof ? CSUM : LOAD;
          end
        end
        LOAD: begin
          if (in_rd_en) begin
            if (in_sof) begin
              len     <= 11'd1;
              udp_acc <= {16'h0000, din, 8'h00};
              state   <= in_eof ? CSUM : LOAD;
            end else if (len == MAX_LEN) begin
              len     <= '0;
              udp_acc <= '0;
              state   <= in_eof ? IDLE : DROP;
            end else begin
              len     <= len + 11'd1;
              udp_acc <= udp_acc + (len[0] ? {24'h0, din} : {16'h0000, din, 8'h00});
              if (in_eof) state <= CSUM;
            end
          end
        end
        DROP: begin
          if (in_rd_en && in_eof) state <= IDLE;
        end
        CSUM: begin
          if (!csum_phase) begin
            csum_phase <= 1'b1;
            udp_acc <= udp_acc
                     + {16'h0000, SRC_IP[31:16]} + {16'h0000, SRC_IP[15:0]}
                     + {16'h0000, DST_IP[31:16]} + {16'h0000, DST_IP[15:0]}
                     + {24'h0, IP_PROTO_UDP} + {16'h0000, udp_len} + {16'h0000, udp_len}
                     + {16'h0000, SRC_PORT} + {16'h0000, DST_PORT};
            ip_acc  <= 32'h0000_4500 + {16'h0000, total_len} + {16'h0000, ident}
                     + 32'h0000_4000 + {16'h0000, TTL, IP_PROTO_UDP}
                     + {16'h0000, SRC_IP[31:16]} + {16'h0000, SRC_IP[15:0]}
                     + {16'h0000, DST_IP[31:16]} + {16'h0000, DST_IP[15:0]};
          end else begin
            csum_phase <= 1'b0;
            // A zero UDP checksum means "none", so it is transmitted as all ones.
            udp_csum   <= (csum_fold(udp_acc) == 16'hFFFF) ? 16'hFFFF : ~csum_fold(udp_acc);
            ip_csum    <= ~csum_fold(ip_acc);
            hcnt       <= '0;
            state      <= HDR;
          end
        end
        HDR: begin
          if (out_wr_en) begin
            if (hcnt == HDR_LAST) begin
              hcnt    <= '0;
              pay_idx <= '0;
              state   <= PAY;
            end else begin
              hcnt <= hcnt + 6'd1;
            end
          end
        end
        PAY: begin
          if (out_wr_en) begin
            if (last_pay) begin
              pay_idx <= '0;
              len     <= '0;
              udp_acc <= '0;
              ident   <= ident + 16'd1;
              state   <= IDLE;
            end else begin
              pay_idx <= pay_idx + 11'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_builder.sv
// Scoreboard bench for udp_builder: stimulus queues payload bytes into a
// modelled show-ahead input FIFO and pushes expected output bytes; a monitor
// pops and compares on every output write.
module tb_udp_builder;

  localparam logic [47:0] SMAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] DMAC  = 48'h02_00_00_00_00_02;
  localparam logic [31:0] SIP   = 32'h0A00_0001;
  localparam logic [31:0] DIP   = 32'h0A00_0002;
  localparam logic [15:0] SPORT = 16'd1234;
  localparam logic [15:0] DPORT = 16'd80;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       in_sof = 1'b0;
  logic       in_eof = 1'b0;
  logic       in_empty = 1'b1;
  logic       in_rd_en;
  logic [7:0] dout;
  logic       out_sof;
  logic       out_eof;
  logic       out_wr_en;
  logic       out_full = 1'b0;

  always #5 clock = ~clock;

  udp_builder #(
    .MAX_PAYLOAD (1472),
    .SRC_MAC     (SMAC),
    .DST_MAC     (DMAC),
    .SRC_IP      (SIP),
    .DST_IP      (DIP),
    .SRC_PORT    (SPORT),
    .DST_PORT    (DPORT),
    .TTL         (8'd64)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .dout      (dout),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_wr_en (out_wr_en),
    .out_full  (out_full)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t      tx_q[$];
  beat_t      exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] basic_exp [46];
  logic [15:0] model_ident = 16'd0;
  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int eof_seen = 0;
  int eof_exp = 0;
  int frame_pos = 0;
  logic bp_en = 1'b0;

  // Input FIFO model: pop decided from the handshake seen before the edge,
  // new head presented just after the edge; also drives random backpressure.
  initial begin : feeder
    bit p;
    forever begin
      @(negedge clock);
      p = in_rd_en && !in_empty;
      @(posedge clock);
      #1;
      if (p && tx_q.size() > 0) tx_q.delete(0);
      if (tx_q.size() > 0) begin
        din      = tx_q[0].data;
        in_sof   = tx_q[0].sof;
        in_eof   = tx_q[0].eof;
        in_empty = 1'b0;
      end else begin
        din      = 8'h00;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_empty = 1'b1;
      end
      out_full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: one line per written byte that disagrees with the scoreboard
  initial begin : monitor
    beat_t got;
    beat_t want;
    forever begin
      @(negedge clock);
      if (out_wr_en) begin
        got = '{data: dout, sof: out_sof, eof: out_eof};
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte pos %0d got %02h sof %0b eof %0b required no write",
                   frame_pos, got.data, got.sof, got.eof);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL byte_%0d got %02h sof %0b eof %0b required %02h sof %0b eof %0b",
                     frame_pos, got.data, got.sof, got.eof, want.data, want.sof, want.eof);
          end
        end
        if (out_eof) begin
          eof_seen++;
          frame_pos = 0;
        end else begin
          frame_pos++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] oc_fold(input int unsigned v);
    int unsigned t;
    t = v;
    while (t > 32'hFFFF) t = (t & 32'hFFFF) + (t >> 16);
    return t[15:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, req);
    end
  endtask

  // Queue pay_q into the input FIFO with optional sof on the first / eof on the last byte
  task automatic send(input bit sof_first, input bit eof_last);
    int n;
    n = pay_q.size();
    for (int i = 0; i < n; i++)
      tx_q.push_back('{data: pay_q[i], sof: (sof_first && i == 0), eof: (eof_last && i == n - 1)});
  endtask

  task automatic fill(input int n, input int seed);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'(i * 7 + seed));
  endtask

  // Reference frame for pay_q using the bench's running ident
  task automatic expect_frame();
    logic [7:0]  fr[$];
    logic [15:0] wd [15];
    logic [47:0] dm, sm;
    logic [31:0] si, di;
    logic [15:0] tl, ul, ipc, udc, w;
    int n;
    int unsigned s;
    n  = pay_q.size();
    dm = DMAC; sm = SMAC; si = SIP; di = DIP;
    tl = 16'(28 + n);
    ul = 16'(8 + n);
    s  = 32'h4500 + 32'(tl) + 32'(model_ident) + 32'h4000 + 32'h4011
       + 32'(si[31:16]) + 32'(si[15:0]) + 32'(di[31:16]) + 32'(di[15:0]);
    ipc = ~oc_fold(s);
    s  = 32'(si[31:16]) + 32'(si[15:0]) + 32'(di[31:16]) + 32'(di[15:0])
       + 32'h0011 + 32'(ul) + 32'(SPORT) + 32'(DPORT) + 32'(ul);
    for (int i = 0; i < n; i += 2) begin
      w = {pay_q[i], (i + 1 < n) ? pay_q[i + 1] : 8'h00};
      s += 32'(w);
    end
    udc = ~oc_fold(s);
    if (udc == 16'h0000) udc = 16'hFFFF;
    for (int i = 5; i >= 0; i--) fr.push_back(dm[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(sm[i*8 +: 8]);
    wd[0] = 16'h0800; wd[1] = 16'h4500; wd[2] = tl; wd[3] = model_ident;
    wd[4] = 16'h4000; wd[5] = 16'h4011; wd[6] = ipc;
    wd[7] = si[31:16]; wd[8] = si[15:0]; wd[9] = di[31:16]; wd[10] = di[15:0];
    wd[11] = SPORT; wd[12] = DPORT; wd[13] = ul; wd[14] = udc;
    for (int i = 0; i < 15; i++) begin
      fr.push_back(wd[i][15:8]);
      fr.push_back(wd[i][7:0]);
    end
    for (int i = 0; i < n; i++) fr.push_back(pay_q[i]);
    for (int i = 0; i < fr.size(); i++)
      exp_q.push_back('{data: fr[i], sof: (i == 0), eof: (i == fr.size() - 1)});
    model_ident++;
    eof_exp++;
  endtask

  // Wait (bounded) until input and scoreboard drain, then make sure nothing is pending
  task automatic wait_done(input int budget, input string nm);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || tx_q.size() != 0) && c < budget) begin
      tick(1);
      c++;
    end
    tick(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d bytes outstanding required 0", nm, exp_q.size());
    end
  endtask

  initial begin : stimulus
    int start;
    int c;
    basic_exp = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                  8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00,
                  8'h40, 8'h00, 8'h40, 8'h11, 8'h26, 8'hCB,
                  8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
                  8'h04, 8'hD2, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hE2, 8'hAB,
                  8'h01, 8'h02, 8'h03, 8'h04};

    // Reset with a stray non-sof byte waiting at the FIFO head
    tx_q.push_back('{data: 8'h5A, sof: 1'b0, eof: 1'b0});
    tick(3);
    @(negedge clock);
    chk("reset_in_rd_en", 32'(in_rd_en), 32'd0);
    chk("reset_out_wr_en", 32'(out_wr_en), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_out_sof", 32'(out_sof), 32'd0);
    chk("reset_out_eof", 32'(out_eof), 32'd0);
    tick(1);
    reset = 1'b1;

    // Basic frame (hand-computed) followed back-to-back by an odd-length frame
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(1'b1, 1'b1);
    for (int i = 0; i < 46; i++)
      exp_q.push_back('{data: basic_exp[i], sof: (i == 0), eof: (i == 45)});
    model_ident++;
    eof_exp++;
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    send(1'b1, 1'b1);
    expect_frame();
    wait_done(400, "basic_odd");

    // Backpressure: random out_full must not alter the byte stream
    bp_en = 1'b1;
    fill(7, 3);
    send(1'b1, 1'b1);
    expect_frame();
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(1'b1, 1'b1);
    expect_frame();
    wait_done(1000, "backpressure");
    bp_en = 1'b0;
    tick(2);

    // Oversize frame is dropped; the next one keeps the ident sequence
    fill(1473, 1);
    send(1'b1, 1'b1);
    fill(10, 9);
    send(1'b1, 1'b1);
    expect_frame();
    wait_done(3000, "oversize");

    // Framing errors: stray bytes, then a restart by sof inside LOAD
    pay_q = '{8'h11, 8'h22};
    send(1'b0, 1'b0);
    pay_q = '{8'h33, 8'h44, 8'h55};
    send(1'b1, 1'b0);
    fill(5, 100);
    send(1'b1, 1'b1);
    expect_frame();
    wait_done(400, "framing");

    // Reset during PAY abandons the frame and clears ident
    start = wr_seen;
    fill(20, 50);
    send(1'b1, 1'b1);
    expect_frame();
    c = 0;
    while (wr_seen < start + 45 && c < 300) begin
      tick(1);
      c++;
    end
    checks++;
    if (wr_seen < start + 45) begin
      errors++;
      $display("FAIL reach_pay got %0d writes required %0d", wr_seen - start, 45);
    end
    reset = 1'b0;
    exp_q.delete();
    eof_exp--;
    frame_pos = 0;
    model_ident = 16'd0;
    @(posedge clock);
    @(negedge clock);
    chk("midreset_out_wr_en", 32'(out_wr_en), 32'd0);
    chk("midreset_dout", 32'(dout), 32'd0);
    chk("midreset_out_sof", 32'(out_sof), 32'd0);
    chk("midreset_out_eof", 32'(out_eof), 32'd0);
    chk("midreset_in_rd_en", 32'(in_rd_en), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(4);
    fill(5, 200);
    send(1'b1, 1'b1);
    expect_frame();
    wait_done(400, "after_reset");

    chk("frames_completed", 32'(eof_seen), 32'(eof_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
